// File: rtl/ghost_scheduler_pkg.sv
// ghost_scheduler_pkg
// Shared definitions for the ghost scheduler: global mode codes driven on the
// mode output, the base scatter/chase state encoding, and a counter-width
// helper used to size every internal counter from its maximum value.
package ghost_scheduler_pkg;

  // Global mode codes seen by the ghost controllers
  localparam logic [1:0] MODE_SCATTER = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_FRIGHT  = 2'd2;

  // Index of the final scatter/chase phase; its chase never ends
  localparam logic [1:0] LAST_PHASE = 2'd3;

  // Base timetable states (fright is an overlay, not a state)
  typedef enum logic [1:0] {
    ST_SCATTER       = 2'd0,
    ST_CHASE         = 2'd1,
    ST_CHASE_FOREVER = 2'd2
  } mode_state_e;

  // Bits needed to hold the value max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val > 32'sd1) ? $clog2(max_val + 32'sd1) : 32'sd1;
  endfunction

endpackage

// File: rtl/ghost_scheduler_frame_ticker.sv
// ghost_scheduler_frame_ticker
// Divides the system clock into movement frames. The counter runs
// 0..TICK_DIV-1 while enabled and holds otherwise; o_frame_tick is a
// registered one-cycle pulse in the cycle the counter has wrapped to 0.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_clr        synchronous clear (round restart)
//   i_en         count enable (game running)
//   o_frame_tick one-cycle frame boundary pulse
module ghost_scheduler_frame_ticker
  import ghost_scheduler_pkg::*;
#(
  parameter int TICK_DIV = 2500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_frame_tick
);

  localparam int CW = cnt_width(TICK_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Cycle counter and registered wrap pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1'b1);
        r_tick <= 1'b0;
      end
    end else begin
      r_cnt  <= r_cnt;
      r_tick <= 1'b0;
    end
  end

  assign o_frame_tick = r_tick;

endmodule

// File: rtl/ghost_scheduler.sv
// ghost_scheduler
// Central sequencer for the ghost movement controllers: staggered one-hot
// step enables after each frame tick, the scatter/chase timetable with a
// frightened overlay, and the frame-based house release schedule.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   game_run              0 freezes counters and suppresses frame ticks
//   power_pellet          energizer eaten (ignored while game_run=0)
//   ghost_eaten[i]        ghost i eaten, ends its frightened state
//   pacman_dead           restart the round (synchronous full clear)
//   frame_tick            frame boundary pulse
//   step_en[i]            ghost i moves one step (at most one bit set)
//   ghost_release[i]      ghost i may leave the house
//   mode                  global mode (scatter / chase / fright)
//   frightened[i]         ghost i is frightened
module ghost_scheduler
  import ghost_scheduler_pkg::*;
#(
  parameter int NUM_GHOSTS     = 4,
  parameter int TICK_DIV       = 2500000,
  parameter int SCATTER_FRAMES = 140,
  parameter int CHASE_FRAMES   = 400,
  parameter int FRIGHT_FRAMES  = 120,
  parameter int RELEASE_GAP    = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  game_run,
  input  logic                  power_pellet,
  input  logic [NUM_GHOSTS-1:0] ghost_eaten,
  input  logic                  pacman_dead,
  output logic                  frame_tick,
  output logic [NUM_GHOSTS-1:0] step_en,
  output logic [NUM_GHOSTS-1:0] ghost_release,
  output logic [1:0]            mode,
  output logic [NUM_GHOSTS-1:0] frightened
);

  localparam int PHASE_MAX = ((SCATTER_FRAMES > CHASE_FRAMES) ? SCATTER_FRAMES : CHASE_FRAMES) - 1;
  localparam int PW        = cnt_width(PHASE_MAX);
  localparam int FW        = cnt_width(FRIGHT_FRAMES);
  localparam int REL_MAX   = (NUM_GHOSTS - 1) * RELEASE_GAP;
  localparam int RW        = cnt_width(REL_MAX);

  localparam logic [PW-1:0]         SCATTER_LAST = PW'(SCATTER_FRAMES - 1);
  localparam logic [PW-1:0]         CHASE_LAST   = PW'(CHASE_FRAMES - 1);
  localparam logic [FW-1:0]         FRIGHT_LOAD  = FW'(FRIGHT_FRAMES);
  localparam logic [RW-1:0]         REL_SAT      = RW'(REL_MAX);
  localparam logic [NUM_GHOSTS-1:0] FIRST_GHOST  = NUM_GHOSTS'(1);

  logic                  w_tick;
  logic                  w_pellet;
  logic                  w_fright_on;
  logic                  w_phase_adv;
  logic [NUM_GHOSTS-1:0] w_eligible;
  logic [NUM_GHOSTS-1:0] w_rel_set;
  logic [1:0]            w_mode;
  mode_state_e           w_state_nxt;

  logic                  r_half;
  logic [NUM_GHOSTS-1:0] r_pos;
  logic [NUM_GHOSTS-1:0] r_pend;
  logic [NUM_GHOSTS-1:0] r_step;
  logic [NUM_GHOSTS-1:0] r_release;
  logic [NUM_GHOSTS-1:0] r_fright_mask;
  logic [FW-1:0]         r_fright_tmr;
  logic [RW-1:0]         r_rel_cnt;
  logic [PW-1:0]         r_phase_cnt;
  logic [1:0]            r_phase;
  mode_state_e           r_state;

  ghost_scheduler_frame_ticker #(
    .TICK_DIV (TICK_DIV)
  ) u_frame_ticker (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clr        (pacman_dead),
    .i_en         (game_run),
    .o_frame_tick (w_tick)
  );

  // Shared qualifiers: effective pellet, fright activity, sweep eligibility, release thresholds
  always_comb begin
    w_pellet    = power_pellet & game_run;
    w_fright_on = (r_fright_tmr != '0);
    w_phase_adv = w_tick & ~w_fright_on;
    // Frightened ghosts move at half speed: only on frames where the half bit is set
    w_eligible  = r_release & (~r_fright_mask | {NUM_GHOSTS{r_half}});
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      w_rel_set[i] = ((int'(r_rel_cnt) + 32'sd1) == (i * RELEASE_GAP));
    end
  end

  // Step sweep: ghost 0 steps the cycle after the tick, then one ghost per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step <= '0;
      r_pend <= '0;
      r_pos  <= '0;
    end else if (pacman_dead) begin
      r_step <= '0;
      r_pend <= '0;
      r_pos  <= '0;
    end else if (w_tick) begin
      // Eligibility is frozen at the tick so the sweep is unaffected by mid-sweep events
      r_step <= w_eligible & FIRST_GHOST;
      r_pend <= w_eligible;
      r_pos  <= FIRST_GHOST << 1;
    end else if (r_pos != '0) begin
      r_step <= r_pos & r_pend;
      r_pend <= r_pend;
      r_pos  <= r_pos << 1;
    end else begin
      r_step <= '0;
      r_pend <= r_pend;
      r_pos  <= r_pos;
    end
  end

  // Half-speed phase bit: toggles each frame, realigned by a fresh pellet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_half <= 1'b0;
    end else if (pacman_dead || w_pellet) begin
      r_half <= 1'b0;
    end else if (w_tick) begin
      r_half <= ~r_half;
    end else begin
      r_half <= r_half;
    end
  end

  // Fright timer and per-ghost frightened mask
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fright_tmr  <= '0;
      r_fright_mask <= '0;
    end else if (pacman_dead) begin
      r_fright_tmr  <= '0;
      r_fright_mask <= '0;
    end else if (w_pellet) begin
      // A ghost eaten in the pellet cycle is not re-frightened
      r_fright_tmr  <= FRIGHT_LOAD;
      r_fright_mask <= r_release & ~ghost_eaten;
    end else if (w_tick && w_fright_on) begin
      r_fright_tmr  <= r_fright_tmr - FW'(1'b1);
      r_fright_mask <= (r_fright_tmr == FW'(1'b1)) ? '0 : (r_fright_mask & ~ghost_eaten);
    end else begin
      r_fright_tmr  <= r_fright_tmr;
      r_fright_mask <= r_fright_mask & ~ghost_eaten;
    end
  end

  // Release frame counter (saturating) and sticky release bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rel_cnt <= '0;
      r_release <= FIRST_GHOST;
    end else if (pacman_dead) begin
      r_rel_cnt <= '0;
      r_release <= FIRST_GHOST;
    end else if (w_tick && (r_rel_cnt != REL_SAT)) begin
      r_rel_cnt <= r_rel_cnt + RW'(1'b1);
      r_release <= r_release | w_rel_set;
    end else begin
      r_rel_cnt <= r_rel_cnt;
      r_release <= r_release;
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SCATTER;
    end else if (pacman_dead) begin
      r_state <= ST_SCATTER;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Mode FSM: next-state logic, advanced only by frames outside fright
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SCATTER: begin
        if (w_phase_adv && (r_phase_cnt == SCATTER_LAST)) w_state_nxt = ST_CHASE;
        else                                             w_state_nxt = ST_SCATTER;
      end
      ST_CHASE: begin
        if (w_phase_adv && (r_phase_cnt == CHASE_LAST)) begin
          w_state_nxt = (r_phase == LAST_PHASE) ? ST_CHASE_FOREVER : ST_SCATTER;
        end else begin
          w_state_nxt = ST_CHASE;
        end
      end
      ST_CHASE_FOREVER: w_state_nxt = ST_CHASE_FOREVER;
      default:          w_state_nxt = ST_SCATTER;
    endcase
  end

  // Mode FSM: output decode, fright overlay takes precedence
  always_comb begin
    if (w_fright_on) begin
      w_mode = MODE_FRIGHT;
    end else begin
      case (r_state)
        ST_SCATTER:       w_mode = MODE_SCATTER;
        ST_CHASE:         w_mode = MODE_CHASE;
        ST_CHASE_FOREVER: w_mode = MODE_CHASE;
        default:          w_mode = MODE_SCATTER;
      endcase
    end
  end

  // Phase frame counter and phase index; counter restarts on every transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase_cnt <= '0;
      r_phase     <= 2'd0;
    end else if (pacman_dead) begin
      r_phase_cnt <= '0;
      r_phase     <= 2'd0;
    end else if (w_state_nxt != r_state) begin
      r_phase_cnt <= '0;
      r_phase     <= (w_state_nxt == ST_SCATTER) ? (r_phase + 2'd1) : r_phase;
    end else if (w_phase_adv && (r_state != ST_CHASE_FOREVER)) begin
      r_phase_cnt <= r_phase_cnt + PW'(1'b1);
      r_phase     <= r_phase;
    end else begin
      r_phase_cnt <= r_phase_cnt;
      r_phase     <= r_phase;
    end
  end

  assign frame_tick    = w_tick;
  assign step_en       = r_step;
  assign ghost_release = r_release;
  assign mode          = w_mode;
  assign frightened    = r_fright_mask;

endmodule

// File: tb/tb_ghost_scheduler.sv
// tb_ghost_scheduler
// Self-checking bench for ghost_scheduler with small frame parameters.
// A behavioural model tracks totals (running cycles, frames, timetable
// frames, fright frames left) and a table of scheduled step pulses, and
// each scenario task compares the DUT against it and against fixed values.
module tb_ghost_scheduler;

  localparam int NG = 4;
  localparam int TD = 8;
  localparam int SF = 3;
  localparam int CF = 5;
  localparam int FF = 4;
  localparam int RG = 2;

  localparam logic [14:0] RESET_VEC = {1'b0, 4'b0000, 4'b0001, 2'b00, 4'b0000};

  logic        clk;
  logic        reset;
  logic        game_run;
  logic        power_pellet;
  logic [3:0]  ghost_eaten;
  logic        pacman_dead;
  logic        frame_tick;
  logic [3:0]  step_en;
  logic [3:0]  ghost_release;
  logic [1:0]  mode;
  logic [3:0]  frightened;
  logic [14:0] dut_vec;

  int n_chk;
  int n_pass;

  // Behavioural model state
  int         m_cyc;
  int         m_runcyc;
  int         m_ticks;
  int         m_base;
  int         m_fleft;
  logic       m_tick;
  logic       m_half;
  logic [3:0] m_fmask;
  logic [3:0] exp_step [int];

  ghost_scheduler #(
    .NUM_GHOSTS     (NG),
    .TICK_DIV       (TD),
    .SCATTER_FRAMES (SF),
    .CHASE_FRAMES   (CF),
    .FRIGHT_FRAMES  (FF),
    .RELEASE_GAP    (RG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .game_run      (game_run),
    .power_pellet  (power_pellet),
    .ghost_eaten   (ghost_eaten),
    .pacman_dead   (pacman_dead),
    .frame_tick    (frame_tick),
    .step_en       (step_en),
    .ghost_release (ghost_release),
    .mode          (mode),
    .frightened    (frightened)
  );

  assign dut_vec = {frame_tick, step_en, ghost_release, mode, frightened};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ghost i is out of the house once i*RG frames have elapsed
  function automatic logic [3:0] rel_mask(input int t);
    logic [3:0] r;
    for (int i = 0; i < NG; i++) r[i] = (t >= i * RG);
    return r;
  endfunction

  // Timetable: 4 x (3 scatter + 5 chase) frames, then chase for good
  function automatic logic [1:0] sched_mode(input int b);
    if (b < 4 * (SF + CF) && (b % (SF + CF)) < SF) return 2'd0;
    return 2'd1;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [3:0] st;
    st = exp_step.exists(m_cyc) ? exp_step[m_cyc] : 4'b0000;
    return {m_tick, st, rel_mask(m_ticks), (m_fleft > 0) ? 2'd2 : sched_mode(m_base), m_fmask};
  endfunction

  task automatic model_clear();
    m_runcyc = 0; m_ticks = 0; m_base = 0; m_fleft = 0;
    m_tick = 1'b0; m_half = 1'b0; m_fmask = 4'b0000;
    exp_step.delete();
  endtask

  // Advance the model by one clock given the inputs applied during the cycle
  task automatic model_step(input logic run, input logic pel, input logic [3:0] eat, input logic dead);
    logic       cur_tick;
    logic [3:0] rel;
    logic [3:0] tmp;
    int         k;
    cur_tick = m_tick;
    rel      = rel_mask(m_ticks);
    k        = m_cyc;
    m_cyc++;
    if (dead) begin
      model_clear();
      return;
    end
    if (cur_tick) begin
      for (int i = 0; i < NG; i++) begin
        if (rel[i] && (!m_fmask[i] || m_half)) begin
          tmp = exp_step.exists(k + 1 + i) ? exp_step[k + 1 + i] : 4'b0000;
          tmp[i] = 1'b1;
          exp_step[k + 1 + i] = tmp;
        end
      end
    end
    if (cur_tick && m_fleft == 0) m_base++;
    if (pel && run) begin
      m_fleft = FF;
      m_fmask = rel & ~eat;
      m_half  = 1'b0;
    end else begin
      if (cur_tick && m_fleft > 0) begin
        m_fleft--;
        if (m_fleft == 0) m_fmask = 4'b0000;
      end
      m_fmask = m_fmask & ~eat;
      if (cur_tick) m_half = ~m_half;
    end
    if (cur_tick) m_ticks++;
    if (run) m_runcyc++;
    m_tick = run && ((m_runcyc % TD) == 0);
  endtask

  task automatic run_cycle(input logic run, input logic pel, input logic [3:0] eat, input logic dead);
    game_run = run; power_pellet = pel; ghost_eaten = eat; pacman_dead = dead;
    @(posedge clk);
    model_step(run, pel, eat, dead);
    #1;
    power_pellet = 1'b0; ghost_eaten = 4'b0000; pacman_dead = 1'b0;
  endtask

  task automatic restart();
    run_cycle(1'b1, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0; game_run = 1'b0; power_pellet = 1'b0; ghost_eaten = 4'b0000; pacman_dead = 1'b0;
    m_cyc = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dut_vec !== RESET_VEC) $display("FAIL reset_hold dut=%h required=%h", dut_vec, RESET_VEC);
    else n_pass++;
    reset = 1'b1;
    run_cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    n_chk++;
    if (dut_vec !== RESET_VEC) $display("FAIL reset_release dut=%h required=%h", dut_vec, RESET_VEC);
    else n_pass++;
  endtask

  task automatic test_frames_release();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 64; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      ticks += int'(frame_tick);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL frames cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (ticks !== 8) $display("FAIL tick_count dut=%0d required=8", ticks);
    else n_pass++;
    n_chk++;
    if (ghost_release !== 4'b1111) $display("FAIL release_all dut=%b required=1111", ghost_release);
    else n_pass++;
  endtask

  task automatic test_mode_schedule();
    restart();
    for (int i = 0; i < 300; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL mode_sched cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (mode !== 2'd1) $display("FAIL chase_forever dut=%0d required=1", mode);
    else n_pass++;
  endtask

  task automatic test_fright();
    int steps0;
    steps0 = 0;
    restart();
    repeat (59) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    run_cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    n_chk++;
    if ({mode, frightened} !== {2'd2, 4'b1111}) $display("FAIL fright_start dut=%0d/%b required=2/1111", mode, frightened);
    else n_pass++;
    for (int i = 0; i < 34; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      steps0 += int'(step_en[0]);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL fright cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (steps0 !== 2) $display("FAIL fright_half_speed dut=%0d required=2", steps0);
    else n_pass++;
    repeat (3) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    n_chk++;
    if (mode !== 2'd0) $display("FAIL phase_frozen dut=%0d required=0", mode);
    else n_pass++;
  endtask

  task automatic test_ghost_eaten();
    int steps2;
    steps2 = 0;
    restart();
    repeat (59) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    run_cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    repeat (3) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    run_cycle(1'b1, 1'b0, 4'b0100, 1'b0);
    n_chk++;
    if (frightened !== 4'b1011) $display("FAIL eaten_mask dut=%b required=1011", frightened);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      steps2 += int'(step_en[2]);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL eaten cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (steps2 !== 4) $display("FAIL eaten_full_speed dut=%0d required=4", steps2);
    else n_pass++;
  endtask

  task automatic test_pellet_and_eaten();
    restart();
    repeat (59) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    run_cycle(1'b1, 1'b1, 4'b0001, 1'b0);
    n_chk++;
    if ({mode, frightened} !== {2'd2, 4'b1110}) $display("FAIL pellet_eaten dut=%0d/%b required=2/1110", mode, frightened);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL pellet_eaten_run cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_dead_mid_sweep();
    bit found;
    found = 1'b0;
    restart();
    repeat (50) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      found = (frame_tick === 1'b1);
    end
    n_chk++;
    if (!found) $display("FAIL dead_wait_tick dut=no_tick required=tick_within_20");
    else n_pass++;
    run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    n_chk++;
    if (step_en !== 4'b0001) $display("FAIL sweep_first dut=%b required=0001", step_en);
    else n_pass++;
    run_cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    n_chk++;
    if (dut_vec !== RESET_VEC) $display("FAIL dead_reset dut=%h required=%h", dut_vec, RESET_VEC);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      n_chk++;
      if (step_en !== 4'b0000) $display("FAIL sweep_aborted dut=%b required=0000", step_en);
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    int ticks;
    ticks = 0;
    restart();
    repeat (4) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b0, 1'b0, 4'b0000, 1'b0);
      ticks += int'(frame_tick);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL pause cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (ticks !== 0) $display("FAIL pause_ticks dut=%0d required=0", ticks);
    else n_pass++;
    repeat (4) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    n_chk++;
    if (frame_tick !== 1'b1) $display("FAIL pause_resume dut=%b required=1", frame_tick);
    else n_pass++;
  endtask

  task automatic test_random();
    logic       run;
    logic       pel;
    logic       dead;
    logic [3:0] eat;
    restart();
    for (int i = 0; i < 800; i++) begin
      run  = ($urandom_range(0, 9) != 0);
      pel  = ($urandom_range(0, 39) == 0);
      eat  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      dead = ($urandom_range(0, 299) == 0);
      run_cycle(run, pel, eat, dead);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL random cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    restart();
    repeat (59) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    run_cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    repeat (10) run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    n_chk++;
    if (dut_vec !== RESET_VEC) $display("FAIL async_reset dut=%h required=%h", dut_vec, RESET_VEC);
    else n_pass++;
    model_clear();
    @(posedge clk);
    m_cyc++;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b1, 1'b0, 4'b0000, 1'b0);
      n_chk++;
      if (dut_vec !== exp_vec()) $display("FAIL after_async cyc=%0d dut=%h model=%h", m_cyc, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_frames_release();
    test_mode_schedule();
    test_fright();
    test_ghost_eaten();
    test_pellet_and_eaten();
    test_dead_mid_sweep();
    test_pause();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
